// File: rtl/uart_rx_fifo_if.sv
// Ready/valid byte stream carried out of the UART receiver, plus the FIFO occupancy.
// The receiver drives the master side and the consumer uses the slave side.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic                          rx_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output rx_data,
    output rx_valid,
    output fifo_count,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  fifo_count,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver sampling each bit at mid-period, feeding a first-word-fall-through
// receive FIFO with sticky overrun and framing-error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ser_rx,
  input  logic           clear_err,
  output logic           overrun,
  output logic           frame_err,
  uart_rx_fifo_if.master rx
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      idx_r;
  logic [7:0]      shift_r;

  logic            sync1_r;
  logic            sync2_r;
  logic            prev_r;

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;

  logic            fall_s;
  logic            stop_end_s;
  logic            push_s;
  logic            ferr_set_s;
  logic            pop_s;
  logic            push_ok_s;
  logic            ovr_set_s;
  logic            valid_s;
  logic [7:0]      rx_data_s;

  // Two-flop synchronizer plus the previous-value register used for start detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= ser_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign fall_s     = prev_r & ~sync2_r;
  assign stop_end_s = (state_r == STOP) && (cnt_r == CNT_FULL);
  assign push_s     = stop_end_s & sync2_r;
  assign ferr_set_s = stop_end_s & ~sync2_r;

  // Frame deserializer: start validation at half a bit, then one sample per bit period.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r <= START;
            cnt_r   <= {CW{1'b0}};
          end
        end
        START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= 3'd0;
            if (!sync2_r) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == CNT_FULL) begin
            cnt_r   <= {CW{1'b0}};
            shift_r <= {sync2_r, shift_r[7:1]};
            if (idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (cnt_r == CNT_FULL) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign valid_s   = (count_r != {CNTW{1'b0}});
  assign pop_s     = valid_s & rx.rx_ready;
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign push_ok_s = push_s & ((count_r < DEPTH) | pop_s);
  assign ovr_set_s = push_s & ~push_ok_s;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNTW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set_s) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
      if (ferr_set_s) begin
        frame_err <= 1'b1;
      end else if (clear_err) begin
        frame_err <= 1'b0;
      end
    end
  end

  // Head byte is forced to zero when empty since the RAM slot is stale.
  always_comb begin
    rx_data_s = 8'h00;
    if (valid_s) begin
      rx_data_s = mem_r[rd_ptr_r];
    end else begin
      rx_data_s = 8'h00;
    end
  end

  assign rx.rx_data    = rx_data_s;
  assign rx.rx_valid   = valid_s;
  assign rx.fifo_count = count_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo, checked against a queue-based model
// of the received byte stream and the sticky flags.
module tb_uart_rx_fifo;

  localparam int C     = 16;
  localparam int DEPTH = 8;

  logic clock;
  logic reset;
  logic ser_rx;
  logic clear_err;
  logic overrun;
  logic frame_err;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ser_rx    (ser_rx),
    .clear_err (clear_err),
    .overrun   (overrun),
    .frame_err (frame_err),
    .rx        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: bytes expected in the FIFO, in order, plus the sticky flags.
  logic [7:0] exp_q [$];
  logic       m_ovr;
  logic       m_ferr;

  int         cyc = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  int         hi_cnt = 0;
  logic       vprev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor the valid rise time, its byte, and how many cycles valid is high.
  always @(negedge clock) begin
    if (bus.rx_valid && !vprev) begin
      rise_cyc  <= cyc;
      rise_data <= bus.rx_data;
    end
    if (bus.rx_valid) hi_cnt <= hi_cnt + 1;
    vprev <= bus.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(bus.fifo_count), 32'(exp_q.size()));
    check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
    if (exp_q.size() > 0) check({tag, "_head"}, 32'(bus.rx_data), 32'(exp_q[0]));
    else                  check({tag, "_valid"}, 32'(bus.rx_valid), 32'd0);
  endtask

  // One 8N1 frame; optionally pops on the stop-sample edge or pulses reset in data bit 3.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit pop_at_stop, input bit rst_mid);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      ser_rx = bits[k];
      for (int i = 0; i < C; i++) begin
        @(posedge clock);
        #1;
        if (rst_mid && k == 4 && i == 1) reset = 1'b1;
        if (rst_mid && k == 4 && i == 2) reset = 1'b0;
        if (pop_at_stop && k == 9 && i == C / 2 + 1) begin
          check("pop_stop_valid", 32'(bus.rx_valid), 32'd1);
          if (exp_q.size() > 0) check("pop_stop_head", 32'(bus.rx_data), 32'(exp_q[0]));
          bus.rx_ready = 1'b1;
        end
        if (pop_at_stop && k == 9 && i == C / 2 + 2) bus.rx_ready = 1'b0;
      end
    end
    if (!stop) begin
      ser_rx = 1'b1;
      tick(C);
    end
    if (rst_mid) begin
      exp_q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else if (!stop) begin
      m_ferr = 1'b1;
    end else begin
      if (pop_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < DEPTH + 1; n++) begin
      if (exp_q.size() > 0) begin
        check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.rx_data), 32'(exp_q[0]));
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        void'(exp_q.pop_front());
      end
    end
    check({tag, "_empty"}, 32'(bus.rx_valid), 32'd0);
  endtask

  task automatic clear_flags();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    int         start_cyc;
    int         hi_base;
    int         lat;
    logic [7:0] rb;
    logic       rs;

    reset        = 1'b1;
    ser_rx       = 1'b1;
    clear_err    = 1'b0;
    bus.rx_ready = 1'b0;
    m_ovr        = 1'b0;
    m_ferr       = 1'b0;
    tick(3);
    check("rst_data", 32'(bus.rx_data), 32'h00);
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    reset = 1'b0;
    tick(C);
    check_state("reset");

    // Single byte with the consumer always ready: latency and one-cycle valid pulse.
    bus.rx_ready = 1'b1;
    hi_base   = hi_cnt;
    start_cyc = cyc;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    tick(4);
    bus.rx_ready = 1'b0;
    lat = rise_cyc - start_cyc;
    check("latency_in_window", 32'((lat >= 154) && (lat <= 156)), 32'd1);
    check("single_data", 32'(rise_data), 32'h55);
    check("single_pulse_len", 32'(hi_cnt - hi_base), 32'd1);
    check_state("single");

    // Back-to-back frames with no idle gap.
    send_frame(8'hA0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hAB, 1'b1, 1'b0, 1'b0);
    check("b2b_count", 32'(bus.fifo_count), 32'd2);
    check("b2b_head", 32'(bus.rx_data), 32'hA0);
    bus.rx_ready = 1'b1;
    tick(1);
    check("b2b_second", 32'(bus.rx_data), 32'hAB);
    tick(1);
    bus.rx_ready = 1'b0;
    check("b2b_empty", 32'(bus.rx_valid), 32'd0);
    exp_q.delete();

    // Short low glitch on an idle line, then a real frame to show the receiver is idle again.
    ser_rx = 1'b0;
    tick(4);
    ser_rx = 1'b1;
    tick(10);
    check_state("glitch");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    check_state("after_glitch");
    drain("after_glitch");

    // Framing error, then clear.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_flag", 32'(frame_err), 32'd1);
    check_state("ferr");
    clear_flags();
    check("ferr_cleared", 32'(frame_err), 32'd0);

    // Overrun: nine frames into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_count", 32'(bus.fifo_count), 32'd8);
    check_state("ovr");
    drain("ovr_drain");
    clear_flags();
    check_state("ovr_cleared");

    // Same nine frames, popping on the ninth frame's stop-sample edge.
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    send_frame(8'h09, 1'b1, 1'b1, 1'b0);
    check("pop_stop_overrun", 32'(overrun), 32'd0);
    check_state("pop_stop");
    drain("pop_stop_drain");

    // Reset mid-frame with a byte and a frame error already held.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    check_state("pre_reset");
    send_frame(8'hF8, 1'b1, 1'b0, 1'b1);
    check_state("mid_reset");
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    check("rstmid_count", 32'(bus.fifo_count), 32'd1);
    check("rstmid_data", 32'(bus.rx_data), 32'h7E);
    check_state("rstmid_final");
    drain("rstmid_drain");

    // Randomized frames, occasional bad stop bits and gaps, drained every few frames.
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      tick($urandom_range(0, 20));
      send_frame(rb, rs, 1'b0, 1'b0);
      check_state("rand");
      if (i % 4 == 3) begin
        drain("rand_drain");
        clear_flags();
        check_state("rand_clear");
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synthesizable 8N1 UART receiver with a buffered, ready/valid byte output. It sits directly downstream of the management SoC UART transmit pin (`mprj_io[6]`). It deserializes the line, checks framing, and queues received bytes for a consumer such as a bench checker or a loopback/monitor path. It replaces ad-hoc behavioural receivers with a cycle-exact, clock-synchronous one.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit. Must be even and ≥ 4.
- `FIFO_DEPTH`, 8: receive FIFO entries. Must be a power of 2 and ≥ 2.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `ser_rx`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  byte at the FIFO head (first-word-fall-through).
- `rx_valid`  out  1  high when the FIFO is not empty.
- `rx_ready`  in  1  consumer accept; a pop occurs on a clock edge where `rx_valid && rx_ready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `overrun`  out  1  sticky: a good byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `clear_err`  in  1  clears both sticky flags.

## Operation
- Input conditioning: 2-flop synchronizer on `ser_rx`, both flops reset to 1. A start is detected on a 1→0 transition of the synchronized signal, using a registered previous value that also resets to 1.
- The FSM has four states: IDLE, START, DATA, STOP. It also uses a bit-timer `cnt` (0..CLKS_PER_BIT-1), a bit index `idx` (0..7) and a shift register.
  - IDLE: on a detected falling edge, go to START with `cnt`=0.
  - START: when `cnt`=CLKS_PER_BIT/2-1, sample the line. If it is 0, go to DATA with `cnt`=0 and `idx`=0. If it is 1 (glitch), return to IDLE and discard.
  - DATA: when `cnt`=CLKS_PER_BIT-1, sample the line into bit `idx` (LSB first) and reset `cnt`. After `idx`=7, go to STOP.
  - STOP: when `cnt`=CLKS_PER_BIT-1, sample the line.
    - If it is 1, push the byte.
    - If it is 0, set `frame_err` and discard the byte.
    - Either way, return to IDLE. A new start requires the line to return high first, since IDLE only triggers on a falling edge.
- FIFO: circular buffer with read/write pointers and occupancy count.
  - The push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overrun` is set; FIFO contents are unchanged.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop on empty cannot occur, because `rx_valid` is 0.
- Sticky flags: when `clear_err` and a set event occur in the same cycle, the set wins.
- The receiver never stalls on consumer backpressure. Line sampling continues regardless of FIFO state.

## Timing
- Reset values:
  - `rx_valid`=0, `fifo_count`=0, `overrun`=0, `frame_err`=0.
  - `rx_data`=8'h00; the RAM head is undefined, so the output is muxed to 0 when empty.
  - FSM in IDLE; synchronizer at 1.
- Reset mid-frame: takes effect on the next edge. The partial byte is discarded, the FIFO is emptied, flags are cleared, and the FSM returns to IDLE.
- Latency: `rx_valid` rises 3 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT clock edges after the first edge at which `ser_rx` is sampled low. The bench may allow ±1 cycle. With defaults this is 155 cycles.
- Sampling point: mid-bit (CLKS_PER_BIT/2 after the detected start edge, plus multiples of CLKS_PER_BIT). This tolerates about ±45% bit skew over one frame.
- Glitch rejection: a low pulse shorter than CLKS_PER_BIT/2-1 cycles on the synchronized line produces no byte and no flag.
- FIFO read: `rx_data` and `rx_valid` are combinational from FIFO state. After a pop, the next entry appears in the following cycle with no bubble.
- Push-to-visible: a byte pushed at edge N is visible on `rx_data`/`rx_valid` after edge N when the FIFO was empty.
- Back-to-back frames: a stop bit immediately followed by a start bit is received with no gap required.

## Test plan
- Single byte: CLKS_PER_BIT=16, drive 0x55 framed 8N1, `rx_ready`=1.
  - Required: `rx_valid` pulses for 1 cycle with `rx_data`=0x55 at 155±1 cycles after the start edge; no flags set.
- Back-to-back: frames 0xA0 then 0xAB with no idle gap, `rx_ready`=0.
  - Required: `fifo_count`=2 and `rx_data`=0xA0.
  - Then hold `rx_ready`=1 for 2 cycles → `rx_data` shows 0xAB, then `rx_valid`=0.
- Glitch: a 4-cycle low pulse on an idle line.
  - Required: no push, `fifo_count` stays 0, FSM back in IDLE within 10 cycles.
- Framing error: frame 0x3C with the stop bit driven 0.
  - Required: `frame_err`=1, `fifo_count`=0.
  - Pulse `clear_err` → `frame_err`=0.
- Overrun: 9 frames 0x01..0x09 with `rx_ready`=0.
  - Required: `fifo_count`=8 and `overrun`=1; draining yields 0x01..0x08 in order, and 0x09 is absent.
  - Repeat with a pop on the stop-sample cycle of frame 9 → accepted, no overrun.
- Reset mid-frame: assert `reset` for 1 cycle during DATA bit 3 of a frame, then send 0x7E.
  - Required: only 0x7E is received, all flags are 0, `fifo_count` ends at 1.
